// File: rtl/bru_pkg.sv
// Shared definitions for the branch redirect unit: opcodes, branch func3 codes, BTB entry layout.
// Entry fields are sized for the widest supported XLEN; narrower builds zero-extend into them.
package bru_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned BTB_FIELD_W = 64;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_RESET    = 2'b01;
    localparam ctr2_t CTR_WEAK_T   = 2'b10;
    localparam ctr2_t CTR_STRONG_T = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        ctr2_t                  ctr;
    } btb_entry_t;

    function automatic ctr2_t ctr_update(input ctr2_t c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Bus between the pipeline (master: fetch PC, DE/EX instruction state) and the redirect unit (slave).
// Redirect/flush/prediction are combinational on the slave side; statistics are registered.
interface branch_redirect_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) ();
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    logic             de_valid;
    logic [6:0]       de_opcode;
    logic [XLEN-1:0]  de_pc;
    logic [XLEN-1:0]  de_j_immed;
    logic             de_pred_taken;
    logic [XLEN-1:0]  de_pred_target;

    logic             ex_valid;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_func3;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_b_immed;
    logic [XLEN-1:0]  ex_i_immed;
    logic [XLEN-1:0]  ex_rs1;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             br_eq;
    logic             br_lt;
    logic             br_ltu;

    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if;
    logic             flush_de;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output if_pc,
        output de_valid, de_opcode, de_pc, de_j_immed, de_pred_taken, de_pred_target,
        output ex_valid, ex_opcode, ex_func3, ex_pc, ex_b_immed, ex_i_immed, ex_rs1,
        output ex_pred_taken, ex_pred_target, br_eq, br_lt, br_ltu,
        input  pred_taken, pred_target, redirect, redirect_pc, flush_if, flush_de,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_pc,
        input  de_valid, de_opcode, de_pc, de_j_immed, de_pred_taken, de_pred_target,
        input  ex_valid, ex_opcode, ex_func3, ex_pc, ex_b_immed, ex_i_immed, ex_rs1,
        input  ex_pred_taken, ex_pred_target, br_eq, br_lt, br_ltu,
        output pred_taken, pred_target, redirect, redirect_pc, flush_if, flush_de,
        output branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two async read ports (fetch, EX training) and one write port with EX over DE priority.
// Only built when BRU_PREDICT_EN is defined; reset clears valid bits and sets counters weakly not-taken.
`ifdef BRU_PREDICT_EN
module btb_table
    import bru_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] if_idx_i,
    output btb_entry_t       if_ent_o,
    input  logic [IDX_W-1:0] ex_idx_i,
    output btb_entry_t       ex_ent_o,
    input  logic             ex_we_i,
    input  btb_entry_t       ex_wdat_i,
    input  logic             de_we_i,
    input  logic [IDX_W-1:0] de_idx_i,
    input  btb_entry_t       de_wdat_i
);

    btb_entry_t mem_q [ENTRIES];
    logic       de_wr_ok;

    assign if_ent_o = mem_q[if_idx_i];
    assign ex_ent_o = mem_q[ex_idx_i];

    // A DE allocation colliding with an EX update on the same slot is dropped.
    assign de_wr_ok = de_we_i && !(ex_we_i && (ex_idx_i == de_idx_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i]     <= '0;
                mem_q[i].ctr <= CTR_RESET;
            end
        end else begin
            if (de_wr_ok) mem_q[de_idx_i] <= de_wdat_i;
            if (ex_we_i)  mem_q[ex_idx_i] <= ex_wdat_i;
        end
    end

endmodule
`endif

// File: rtl/branch_redirect_unit.sv
// Fetch prediction, EX branch/JALR and DE JAL resolution, single redirect with flush masks, mispredict stats.
// BRU_PREDICT_EN builds the BTB and 2-bit counters; without it every taken control transfer redirects.
module branch_redirect_unit
    import bru_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic                   CLK,
    input logic                   RST,
    branch_redirect_unit_if.slave bus
);

    logic            ex_is_br, ex_is_jalr, ex_taken, ex_redir;
    logic            de_is_jal, de_redir;
    logic            br_fix_tgt, br_fix_seq, jal_pred_ok;
    logic [XLEN-1:0] br_tgt, ex_seq_pc, jalr_tgt, jal_tgt, if_seq_pc, ex_redir_pc;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    assign ex_is_br   = bus.ex_valid && (bus.ex_opcode == OP_BRANCH);
    assign ex_is_jalr = bus.ex_valid && (bus.ex_opcode == OP_JALR);
    assign de_is_jal  = bus.de_valid && (bus.de_opcode == OP_JAL);

    always_comb begin
        ex_taken = 1'b0;
        case (bus.ex_func3)
            F3_BEQ:  ex_taken =  bus.br_eq;
            F3_BNE:  ex_taken = !bus.br_eq;
            F3_BLT:  ex_taken =  bus.br_lt;
            F3_BGE:  ex_taken = !bus.br_lt;
            F3_BLTU: ex_taken =  bus.br_ltu;
            F3_BGEU: ex_taken = !bus.br_ltu;
            default: ex_taken = 1'b0;
        endcase
    end

    assign br_tgt    = bus.ex_pc + bus.ex_b_immed;
    assign ex_seq_pc = bus.ex_pc + XLEN'(4);
    assign jalr_tgt  = (bus.ex_rs1 + bus.ex_i_immed) & ~XLEN'(1);
    assign jal_tgt   = bus.de_pc + bus.de_j_immed;
    assign if_seq_pc = bus.if_pc + XLEN'(4);

`ifdef BRU_PREDICT_EN
    assign br_fix_tgt  = ex_taken && (!bus.ex_pred_taken || (bus.ex_pred_target != br_tgt));
    assign br_fix_seq  = !ex_taken && bus.ex_pred_taken;
    assign jal_pred_ok = bus.de_pred_taken && (bus.de_pred_target == jal_tgt);
`else
    // Without a predictor nothing is ever fetched down a taken path.
    assign br_fix_tgt  = ex_taken;
    assign br_fix_seq  = 1'b0;
    assign jal_pred_ok = 1'b0;
`endif

    always_comb begin
        ex_redir    = 1'b0;
        ex_redir_pc = br_tgt;
        if (ex_is_jalr) begin
            ex_redir    = 1'b1;
            ex_redir_pc = jalr_tgt;
        end else if (ex_is_br && br_fix_tgt) begin
            ex_redir    = 1'b1;
            ex_redir_pc = br_tgt;
        end else if (ex_is_br && br_fix_seq) begin
            ex_redir    = 1'b1;
            ex_redir_pc = ex_seq_pc;
        end
    end

    assign de_redir        = de_is_jal && !jal_pred_ok;
    assign bus.redirect    = ex_redir || de_redir;
    assign bus.redirect_pc = ex_redir ? ex_redir_pc : jal_tgt;
    assign bus.flush_if    = ex_redir || de_redir;
    assign bus.flush_de    = ex_redir;

`ifdef BRU_PREDICT_EN
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       if_ent, ex_ent, ex_wdat, de_wdat;
    logic [IDX_W-1:0] if_idx, ex_idx, de_idx;
    logic [TAG_W-1:0] if_tag, ex_tag, de_tag;
    logic             if_hit, ex_hit, ex_we, de_we;
    ctr2_t            ex_ctr_nxt;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign if_tag = bus.if_pc[XLEN-1:IDX_W+2];
    assign ex_idx = bus.ex_pc[IDX_W+1:2];
    assign ex_tag = bus.ex_pc[XLEN-1:IDX_W+2];
    assign de_idx = bus.de_pc[IDX_W+1:2];
    assign de_tag = bus.de_pc[XLEN-1:IDX_W+2];

    assign if_hit          = if_ent.valid && (if_ent.tag == BTB_FIELD_W'(if_tag));
    assign bus.pred_taken  = if_hit && (if_ent.ctr >= CTR_WEAK_T);
    assign bus.pred_target = bus.pred_taken ? XLEN'(if_ent.target) : if_seq_pc;

    assign ex_hit     = ex_ent.valid && (ex_ent.tag == BTB_FIELD_W'(ex_tag));
    assign ex_ctr_nxt = ex_hit ? ctr_update(ex_ent.ctr, ex_taken) : CTR_WEAK_T;

    // Hits only write when the counter moves or the stored target is stale; misses allocate only when taken.
    assign ex_we = ex_is_br && (ex_hit ? ((ex_ctr_nxt != ex_ent.ctr) ||
                                          (ex_ent.target != BTB_FIELD_W'(br_tgt)))
                                       : ex_taken);

    always_comb begin
        ex_wdat        = '0;
        ex_wdat.valid  = 1'b1;
        ex_wdat.tag    = BTB_FIELD_W'(ex_tag);
        ex_wdat.target = BTB_FIELD_W'(br_tgt);
        ex_wdat.ctr    = ex_ctr_nxt;
    end

    assign de_we = de_is_jal && !ex_redir;

    always_comb begin
        de_wdat        = '0;
        de_wdat.valid  = 1'b1;
        de_wdat.tag    = BTB_FIELD_W'(de_tag);
        de_wdat.target = BTB_FIELD_W'(jal_tgt);
        de_wdat.ctr    = CTR_STRONG_T;
    end

    btb_table #(
        .ENTRIES (BTB_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk_i     (CLK),
        .rst_i     (RST),
        .if_idx_i  (if_idx),
        .if_ent_o  (if_ent),
        .ex_idx_i  (ex_idx),
        .ex_ent_o  (ex_ent),
        .ex_we_i   (ex_we),
        .ex_wdat_i (ex_wdat),
        .de_we_i   (de_we),
        .de_idx_i  (de_idx),
        .de_wdat_i (de_wdat)
    );
`else
    localparam int unsigned unused_btb_entries = BTB_ENTRIES;
    logic unused_pred;

    assign bus.pred_taken  = 1'b0;
    assign bus.pred_target = if_seq_pc;
    assign unused_pred     = ^{bus.ex_pred_taken, bus.ex_pred_target,
                               bus.de_pred_taken, bus.de_pred_target};
`endif

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (ex_is_br && !(&br_cnt_q))  br_cnt_d  = br_cnt_q + CNT_W'(1);
        if (ex_redir && !(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bus.branch_cnt     = br_cnt_q;
    assign bus.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: expected redirect/flush results queued at drive time, popped at check time.
// Expectations follow BRU_PREDICT_EN so either build of the design can be exercised.
module tb_branch_redirect_unit;
    import bru_pkg::*;

    localparam int unsigned CW   = 5;
    localparam int          MAXC = (1 << CW) - 1;
`ifdef BRU_PREDICT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic        rd;
        logic [31:0] pc;
        logic        fi;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_br  = 0;
    int   m_mis = 0;

    logic [2:0] f_f3  [11] = '{F3_BLT, F3_BGE, F3_BGE, F3_BLTU, F3_BGEU, F3_BGEU,
                               3'b010, F3_BNE, F3_BEQ, F3_BLT, F3_BLTU};
    logic [2:0] f_cmp [11] = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000,
                               3'b111, 3'b100, 3'b011, 3'b101, 3'b010};
    logic       f_tk  [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    branch_redirect_unit_if #(.XLEN(32), .CNT_W(CW)) bus ();

    branch_redirect_unit #(.XLEN(32), .BTB_ENTRIES(16), .CNT_W(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp_v);
        end
    endtask

    task automatic idle();
        bus.de_valid = 0; bus.de_opcode = '0; bus.de_pc = '0; bus.de_j_immed = '0;
        bus.de_pred_taken = 0; bus.de_pred_target = '0;
        bus.ex_valid = 0; bus.ex_opcode = '0; bus.ex_func3 = '0; bus.ex_pc = '0;
        bus.ex_b_immed = '0; bus.ex_i_immed = '0; bus.ex_rs1 = '0;
        bus.ex_pred_taken = 0; bus.ex_pred_target = '0;
        bus.br_eq = 0; bus.br_lt = 0; bus.br_ltu = 0;
    endtask

    task automatic drv_br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [2:0] cmp, input logic pt, input logic [31:0] ptgt);
        bus.ex_valid = 1; bus.ex_opcode = OP_BRANCH; bus.ex_func3 = f3; bus.ex_pc = pc;
        bus.ex_b_immed = imm; {bus.br_eq, bus.br_lt, bus.br_ltu} = cmp;
        bus.ex_pred_taken = pt; bus.ex_pred_target = ptgt;
    endtask

    task automatic drv_jalr(input logic [31:0] rs1, input logic [31:0] imm);
        bus.ex_valid = 1; bus.ex_opcode = OP_JALR; bus.ex_pc = 32'h500;
        bus.ex_rs1 = rs1; bus.ex_i_immed = imm;
    endtask

    task automatic drv_jal(input logic [31:0] pc, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptgt);
        bus.de_valid = 1; bus.de_opcode = OP_JAL; bus.de_pc = pc; bus.de_j_immed = imm;
        bus.de_pred_taken = pt; bus.de_pred_target = ptgt;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({e.nm, "_redirect"}, 32'(bus.redirect), 32'(e.rd));
        if (e.rd) chk({e.nm, "_redirect_pc"}, bus.redirect_pc, e.pc);
        chk({e.nm, "_flush_if"}, 32'(bus.flush_if), 32'(e.fi));
        chk({e.nm, "_flush_de"}, 32'(bus.flush_de), 32'(e.fd));
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled 1 unit later.
    task automatic step(input string nm, input logic [31:0] ifpc, input logic ept,
                        input logic [31:0] eptgt, input logic rd, input logic [31:0] pc,
                        input logic fi, input logic fd, input logic inc_br, input logic inc_mis);
        exp_t e;
        bus.if_pc = ifpc;
        e.nm = nm; e.rd = rd; e.pc = pc; e.fi = fi; e.fd = fd;
        sb_q.push_back(e);
        if (inc_br && m_br < MAXC)   m_br++;
        if (inc_mis && m_mis < MAXC) m_mis++;
        #1;
        chk({nm, "_pred_taken"}, 32'(bus.pred_taken), 32'(ept));
        chk({nm, "_pred_target"}, bus.pred_target, eptgt);
        check_out();
        @(posedge clk);
        #1;
        chk({nm, "_branch_cnt"}, 32'(bus.branch_cnt), 32'(m_br));
        chk({nm, "_mispredict_cnt"}, 32'(bus.mispredict_cnt), 32'(m_mis));
        idle();
    endtask

    initial begin
        idle();
        bus.if_pc = 32'h100;
        #1 rst = 1'b1;
        #2;
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("rst_mispredict_cnt", 32'(bus.mispredict_cnt), 32'd0);
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_flush_if", 32'(bus.flush_if), 32'd0);
        chk("rst_flush_de", 32'(bus.flush_de), 32'd0);
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_pred_target", bus.pred_target, 32'h104);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First BEQ at 0x100 taken with no prediction.
        drv_br(32'h100, F3_BEQ, 32'h20, 3'b100, 1'b0, 32'h0);
        step("beq_first", 32'h100, 1'b0, 32'h104, 1'b1, 32'h120, 1'b1, 1'b1, 1'b1, 1'b1);
        step("look100", 32'h100, PE, PE ? 32'h120 : 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            drv_br(32'h100, F3_BEQ, 32'h20, 3'b100, 1'b1, 32'h120);
            step("beq_again", 32'h100, PE, PE ? 32'h120 : 32'h104,
                 !PE, 32'h120, !PE, !PE, 1'b1, !PE);
        end
        drv_br(32'h100, F3_BEQ, 32'h20, 3'b000, 1'b1, 32'h120);
        step("beq_not_taken", 32'h100, PE, PE ? 32'h120 : 32'h104,
             PE, 32'h104, PE, PE, 1'b1, PE);
        step("look100_after", 32'h100, PE, PE ? 32'h120 : 32'h104,
             1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backward BNE at 0x10 with negative immediate.
        for (int i = 0; i < 3; i++) begin
            drv_br(32'h10, F3_BNE, 32'hFFFF_FFF8, 3'b000, 1'b0, 32'h0);
            step("bne_back", 32'h10, PE && (i > 0), (PE && (i > 0)) ? 32'h08 : 32'h14,
                 1'b1, 32'h08, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        for (int i = 0; i < 11; i++) begin
            drv_br(32'h200, f_f3[i], 32'h10, f_cmp[i], 1'b0, 32'h0);
            step($sformatf("func3_case%0d", i), 32'h700, 1'b0, 32'h704,
                 f_tk[i], 32'h210, f_tk[i], f_tk[i], 1'b1, f_tk[i]);
        end

        drv_br(32'h200, F3_BEQ, 32'h10, 3'b100, 1'b0, 32'h0);
        bus.ex_valid = 1'b0;
        step("ex_invalid", 32'h700, 1'b0, 32'h704, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // JALR in EX beats a JAL in DE; the JAL must not allocate.
        drv_jalr(32'h203, 32'h4);
        drv_jal(32'h80, 32'h10, 1'b0, 32'h0);
        step("jalr_over_jal", 32'h700, 1'b0, 32'h704, 1'b1, 32'h206, 1'b1, 1'b1, 1'b0, 1'b1);
        step("look80", 32'h80, 1'b0, 32'h84, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv_jalr(32'h1000, 32'hFFFF_FFFF);
        step("jalr_neg", 32'h700, 1'b0, 32'h704, 1'b1, 32'hFFE, 1'b1, 1'b1, 1'b0, 1'b1);

        drv_br(32'h100, F3_BEQ, 32'h20, 3'b100, 1'b0, 32'h0);
        drv_jal(32'h40, 32'h80, 1'b0, 32'h0);
        step("br_over_jal", 32'h700, 1'b0, 32'h704, 1'b1, 32'h120, 1'b1, 1'b1, 1'b1, 1'b1);

        // JAL resolution in DE flushes IF only.
        drv_jal(32'h40, 32'h80, 1'b0, 32'h0);
        step("jal_unpred", 32'h40, 1'b0, 32'h44, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv_jal(32'h40, 32'h80, 1'b1, 32'hC0);
        step("jal_pred", 32'h40, PE, PE ? 32'hC0 : 32'h44, !PE, 32'hC0, !PE, 1'b0, 1'b0, 1'b0);
        drv_jal(32'h40, 32'h80, 1'b1, 32'hC4);
        step("jal_bad_tgt", 32'h40, PE, PE ? 32'hC0 : 32'h44, 1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
        drv_jal(32'h40, 32'h80, 1'b0, 32'h0);
        bus.de_valid = 1'b0;
        step("de_invalid", 32'h700, 1'b0, 32'h704, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 36; i++) begin
            drv_jalr(32'h400, 32'h0);
            step("sat_mis", 32'h700, 1'b0, 32'h704, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 36; i++) begin
            drv_br(32'h300, F3_BEQ, 32'h40, 3'b000, 1'b0, 32'h0);
            step("sat_br", 32'h700, 1'b0, 32'h704, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Reset in the middle of a mispredict cycle.
        step("look40", 32'h40, PE, PE ? 32'hC0 : 32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv_br(32'h100, F3_BEQ, 32'h20, 3'b100, 1'b0, 32'h0);
        bus.if_pc = 32'h40;
        #2 rst = 1'b1;
        #1;
        chk("midrst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("midrst_mispredict_cnt", 32'(bus.mispredict_cnt), 32'd0);
        chk("midrst_redirect", 32'(bus.redirect), 32'd1);
        chk("midrst_redirect_pc", bus.redirect_pc, 32'h120);
        chk("midrst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("midrst_pred_target", bus.pred_target, 32'h44);
        @(negedge clk);
        rst = 1'b0;
        idle();
        m_br  = 0;
        m_mis = 0;
        @(posedge clk);
        #1;
        step("post_rst100", 32'h100, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_rst40", 32'h40, 1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Parametrised control-flow unit for the 5-stage pipeline. It predicts at fetch using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and resolves branches and JALR in EX and JAL in DE. It then issues a single redirect with the matching flush masks and trains the predictor. It sits between the fetch PC mux and the DE/EX pipeline registers, and exposes mispredict statistics.

## Interface
- XLEN, 32, datapath and PC width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2
- CNT_W, 32, width of statistics counters
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- if_pc  in  XLEN  fetch PC
- pred_taken  out  1  fetch prediction (combinational from if_pc)
- pred_target  out  XLEN  predicted next PC; if_pc+4 when pred_taken=0
- de_valid, de_opcode[6:0], de_pc[XLEN], de_j_immed[XLEN], de_pred_taken, de_pred_target[XLEN]  in  DE-stage instruction and the prediction carried with it
- ex_valid, ex_opcode[6:0], ex_func3[2:0], ex_pc[XLEN], ex_b_immed[XLEN], ex_i_immed[XLEN], ex_rs1[XLEN], ex_pred_taken, ex_pred_target[XLEN]  in  EX-stage instruction, operands and carried prediction
- br_eq, br_lt, br_ltu  in  1 each  branch comparator results for EX
- redirect  out  1  load redirect_pc into the PC this cycle
- redirect_pc  out  XLEN  corrected next PC
- flush_if  out  1  bubble the IF/DE register
- flush_de  out  1  bubble the DE/EX register
- branch_cnt, mispredict_cnt  out  CNT_W  resolved-branch and EX-redirect counts

## Operation
- Lookup: idx = if_pc[log2(BTB_ENTRIES)+1:2]. tag = the remaining upper bits. Hit = valid[idx] and tag match. pred_taken = hit and ctr[idx][1]. Table reads are asynchronous.
- EX resolution (ex_valid=1):
  - Branch (1100011): taken per func3. BEQ/BNE use br_eq, BLT/BGE use br_lt, BLTU/BGEU use br_ltu; other func3 values mean not taken. Target = ex_pc + ex_b_immed.
  - Mispredict if taken and (!ex_pred_taken or ex_pred_target≠target), then redirect to target.
  - Mispredict if not taken and ex_pred_taken, then redirect to ex_pc+4.
  - JALR (1100111): always redirect to (ex_rs1 + ex_i_immed) & ~1. JALR is never allocated in the BTB.
  - Any EX redirect asserts flush_if and flush_de.
- DE resolution (de_valid=1, opcode 1101111):
  - Target = de_pc + de_j_immed.
  - Redirect unless de_pred_taken and de_pred_target==target. Asserts flush_if only.
- Priority: an EX redirect wins over a DE redirect in the same cycle. The DE JAL is wrong-path and is flushed.
- All arithmetic is modulo 2^XLEN. Immediates arrive already sign-extended.
- Training, on the rising edge:
  - Resolved branch: ctr saturates up when taken and down when not taken.
  - Taken branch that missed the BTB: allocate tag/target with ctr=2'b10.
  - Hit whose target differs: overwrite target.
  - JAL in DE with no redirect suppression: allocate with ctr=2'b11.
  - Same index written by EX and DE in one cycle: the EX write wins, and the DE write is dropped.
- Statistics:
  - branch_cnt increments on each resolved EX branch.
  - mispredict_cnt increments on each EX redirect, including JALR.
  - Both saturate at all-ones.

## Timing
- Lookup, resolution, redirect and flush outputs are combinational, valid in the same cycle. Redirect is a single-cycle pulse with no hold.
- The fetch mux consumes redirect at the next rising edge. The pipeline registers consume the flush signals at the same edge, which sets the flushed stages' valid to 0. Wrong-path instructions therefore never resolve.
- Table and counter updates are visible to lookups from the cycle after the training edge.
- RST is asserted asynchronously:
  - All valid bits clear, all ctr become 2'b01, and both statistics counters clear.
  - Combinational outputs then follow the inputs: redirect=0, flush_if=0 and flush_de=0 whenever ex_valid=de_valid=0.
  - A reset mid-redirect discards the pending training write.

## Configuration
- BRU_PREDICT_EN defined: BTB, counters and training are present as described above.
- BRU_PREDICT_EN undefined: no tables are built. pred_taken=0 and pred_target=if_pc+4. Every taken branch, JAL and JALR redirects. The carried prediction inputs are ignored. Statistics are still present.

## Structure
- Shared package bru_pkg:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - func3 constants for the six branches.
  - typedef ctr2_t for the 2-bit counter.
  - typedef btb_entry_t {valid, tag, target, ctr}.
- One sub-module, btb_table: storage, asynchronous read port, one prioritised write port (EX over DE), and reset clear.

## Test plan
- Reset then a BEQ at 0x100 with br_eq=1 and imm 0x20, no prediction → redirect=1, redirect_pc=0x120, flush_if=flush_de=1, mispredict_cnt=1. Lookup at 0x100 next cycle → pred_taken=1, target 0x120.
- The same BEQ resolved taken three more times, then once not taken with ex_pred_taken=1 → redirect to 0x104. ctr goes 10→11→11→11→10, and pred_taken stays 1.
- JALR in EX with rs1=0x203 and imm=4, plus a JAL in DE in the same cycle → redirect_pc=0x206, flush_de=1, and no DE allocation occurs.
- JAL in DE at 0x40 with imm 0x80, unpredicted → redirect to 0xC0 with flush_if only. Repeating it with de_pred_taken=1 and target 0xC0 → no redirect.
- RST pulsed mid-cycle while a mispredict is in EX → counters read 0 immediately, and a lookup at 0x100 gives pred_taken=0.
- Build without BRU_PREDICT_EN: taken BNE at 0x10 with imm −8 → redirect_pc=0x08 every time, and pred_taken is always 0.
